atm_txn_arbiter: RTL
====================

# atm_txn_arbiter

Shared-account transaction controller for two ATM terminal front-ends. It accepts balance-query, deposit and withdraw requests from two requesters over a req/grant/done handshake. It arbitrates round-robin and executes one transaction at a time against a single internal balance register, flagging insufficient funds, overflow and invalid opcodes. It sits between the per-terminal ATM session FSMs and the account balance storage.

## Interface
- BAL_W, 32, balance register width
- AMT_W, 7, transaction amount width
- INIT_BAL, 1000, balance loaded on reset
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- req  input  2  per-requester transaction request; bit i = terminal i
- op0, op1  input  2 each  opcode: 00 query, 01 deposit, 10 withdraw, 11 invalid
- amt0, amt1  input  AMT_W each  unsigned amount (ignored for query/invalid)
- grant  output  2  one-hot, terminal currently being served
- done  output  2  one-cycle completion pulse to served terminal
- err  output  2  error flag, valid only while matching done bit is high
- balance  output  BAL_W  current balance, registered
- busy  output  1  high while a transaction is in flight (state != IDLE)

## Operation
- States: IDLE, EXEC, RESP.
- IDLE: if req != 0, select winner, set grant, latch winner's op/amt into internal regs, go EXEC; else stay.
- Arbitration: round-robin using 1-bit last_served pointer.
  - Single req: that requester wins.
  - Both req: requester != last_served wins.
  - Pointer reset value 1, so terminal 0 wins first contention after reset.
  - Pointer updates on the grant edge.
- EXEC: apply latched op, register done[winner]=1 and err[winner], go RESP.
  - 00 query: balance unchanged, err=0.
  - 01 deposit: compute balance + amt in BAL_W+1 bits; on carry out, balance unchanged and err=1; else update, err=0.
  - 10 withdraw: if amt > balance, balance unchanged and err=1; else balance -= amt, err=0. amt == balance yields 0, err=0.
  - 11 invalid: balance unchanged, err=1.
  - amt=0 on deposit or withdraw: balance unchanged, err=0.
- RESP: clear grant, done, err; go IDLE.
- Operand latching:
  - op/amt are sampled only on the grant edge.
  - Changes on op/amt or req after that edge do not affect the running transaction.
  - Deasserting req mid-transaction does not abort it; done is still pulsed.
- Requesters drop req in the cycle they see done. A req still high in IDLE is a new transaction.
- Only arithmetic state is the balance register. No wrap-around ever occurs: overflow and underflow are rejected, not truncated.

## Timing
- Reset values (async, immediate): state IDLE, grant 0, done 0, err 0, busy 0, balance INIT_BAL, last_served 1, latched op/amt 0.
- Reset asserted mid-transaction drops it: no done pulse, balance restored to INIT_BAL.
- Latency, with req sampled high at edge N in IDLE:
  - grant and busy high after edge N.
  - balance, done and err updated after edge N+1.
  - grant, done, err and busy low after edge N+2.
- grant is high for 2 cycles; done is high for exactly 1 cycle, coincident with grant's second cycle.
- Throughput: one transaction per 3 cycles. Next grant earliest at edge N+3.
- The new balance is visible on the balance port in the same cycle done is high.
- Simultaneous req rising on both bits in IDLE: one grant, the other waits and is granted at edge N+3 if still held.
- req arriving while busy is ignored until IDLE, with no queueing beyond the held req level.

## Test plan
- Reset, then req=01, op0=10, amt0=100 -> grant=01 after 1 edge, done[0] pulse 1 cycle at edge+2, err[0]=0, balance 1000→900.
- Withdraw 127 repeatedly from balance 100 -> err=1, balance stays 100; withdraw 100 -> balance 0, err=0.
- Both req held continuously with op=01, amt=1 -> grants alternate 01,10,01,10 at 3-cycle spacing; balance increments by 1 per transaction.
- BAL_W=8, INIT_BAL=250, deposit 10 -> err=1, balance 250; deposit 5 -> balance 255, err=0.
- op1=11 -> err[1]=1, balance unchanged. Change amt0 and drop req after grant -> latched values still used, done still pulsed.
- Assert reset during EXEC -> all outputs 0 immediately, balance=1000, no done. First contention after release grants terminal 0.

Source files
------------

// File: rtl/atm_txn_arbiter.sv
// atm_txn_arbiter
//
// Shared-account transaction controller for two ATM terminal front-ends.
// Two requesters issue balance-query, deposit or withdraw transactions over a
// req/grant/done handshake. The controller arbitrates round-robin between
// them and runs one transaction at a time against a single balance register.
// Overflowing deposits, overdrawing withdrawals and invalid opcodes are
// rejected with an error flag, and the balance is left untouched.
//
// Parameters:
//   BAL_W    - balance register width
//   AMT_W    - transaction amount width (must not exceed BAL_W)
//   INIT_BAL - balance loaded on reset
//
// Ports:
//   clk        - system clock, all state on rising edge
//   reset      - asynchronous active-high reset, clears all state
//   req[1:0]   - per-terminal transaction request, bit i = terminal i
//   op0, op1   - opcodes: 00 query, 01 deposit, 10 withdraw, 11 invalid
//   amt0, amt1 - unsigned amounts (ignored for query/invalid)
//   grant[1:0] - one-hot, terminal currently being served
//   done[1:0]  - one-cycle completion pulse to the served terminal
//   err[1:0]   - error flag, valid only while the matching done bit is high
//   balance    - current balance, registered
//   busy       - high while a transaction is in flight
module atm_txn_arbiter #(
  parameter int          BAL_W    = 32,
  parameter int          AMT_W    = 7,
  parameter int unsigned INIT_BAL = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [1:0]       op0,
  input  logic [1:0]       op1,
  input  logic [AMT_W-1:0] amt0,
  input  logic [AMT_W-1:0] amt1,
  output logic [1:0]       grant,
  output logic [1:0]       done,
  output logic [1:0]       err,
  output logic [BAL_W-1:0] balance,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] OP_QUERY    = 2'b00;
  localparam logic [1:0] OP_DEPOSIT  = 2'b01;
  localparam logic [1:0] OP_WITHDRAW = 2'b10;

  state_t            state;
  state_t            next_state;
  logic              last_served;
  logic [1:0]        lat_op;
  logic [AMT_W-1:0]  lat_amt;

  logic              winner;
  logic [BAL_W-1:0]  amt_ext;
  logic [BAL_W:0]    sum;
  logic [BAL_W-1:0]  exec_bal;
  logic              exec_err;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: a transaction always runs IDLE -> EXEC -> RESP, and
  // req is only looked at in IDLE, so late requests simply wait.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req != 2'b00) next_state = EXEC;
      EXEC:    next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Round-robin pick: on contention the terminal not served last time wins.
  always_comb begin
    winner = 1'b0;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_served;
      default: winner = 1'b0;
    endcase
  end

  // Execution of the latched transaction. The deposit sum is one bit wider
  // than the balance so a carry out flags overflow instead of wrapping.
  always_comb begin
    amt_ext  = BAL_W'(lat_amt);
    sum      = {1'b0, balance} + {1'b0, amt_ext};
    exec_bal = balance;
    exec_err = 1'b0;
    case (lat_op)
      OP_QUERY: begin
        exec_err = 1'b0;
      end
      OP_DEPOSIT: begin
        if (sum[BAL_W]) begin
          exec_err = 1'b1;
        end else begin
          exec_bal = sum[BAL_W-1:0];
        end
      end
      OP_WITHDRAW: begin
        if (amt_ext > balance) begin
          exec_err = 1'b1;
        end else begin
          exec_bal = balance - amt_ext;
        end
      end
      default: begin
        exec_err = 1'b1;
      end
    endcase
  end

  // Datapath and handshake registers. The operands are captured on the
  // grant edge so later changes on op/amt/req cannot disturb the running
  // transaction. last_served doubles as the index of the terminal being
  // served while in EXEC/RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant       <= 2'b00;
      done        <= 2'b00;
      err         <= 2'b00;
      balance     <= BAL_W'(INIT_BAL);
      last_served <= 1'b1;
      lat_op      <= 2'b00;
      lat_amt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            grant       <= winner ? 2'b10 : 2'b01;
            last_served <= winner;
            lat_op      <= winner ? op1 : op0;
            lat_amt     <= winner ? amt1 : amt0;
          end
        end
        EXEC: begin
          done    <= last_served ? 2'b10 : 2'b01;
          err     <= last_served ? {exec_err, 1'b0} : {1'b0, exec_err};
          balance <= exec_bal;
        end
        RESP: begin
          grant <= 2'b00;
          done  <= 2'b00;
          err   <= 2'b00;
        end
        default: begin
          grant <= 2'b00;
          done  <= 2'b00;
          err   <= 2'b00;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule
